rnn_seq_engine: RTL and testbench
=================================

// Module: rnn_seq_engine
// PURPOSE
//  Parametrised successor to the single-step RNN accelerator: memory-mapped Elman RNN engine with signed Q-format arithmetic.
//  Buffers a whole input sequence, runs all timesteps autonomously, then computes 2**OUT_BITS dense outputs.
//  Hidden state persists across runs (streaming) unless cleared. Sits behind the HPS bridge as an Avalon-style slave.
// PARAMETERS
//  EMB_BITS  1  log2 input vector length E
//  RNN_BITS  5  log2 hidden size H
//  OUT_BITS  0  log2 number of dense outputs O
//  SEQ_BITS  4  log2 max sequence length S
//  FRAC_BITS 8  fractional bits of the 16-bit signed fixed-point format
// PORTS
//  clk       in   1   clock
//  rst       in   1   synchronous active-high reset
//  read      in   1   bus read strobe
//  write     in   1   bus write strobe
//  addr      in   32  word address
//  data_in   in   32  [15:0] value; [31:24] row/timestep/output idx; [23:16] col/element idx
//  data_out  out  32  read data; 0 when read=0
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous, active-high. All state changes on posedge clk.
//  Address map: 0 CTRL/STATUS; 1 x[t][e]; 2 W[e][j]; 3 U[k][j]; 4 b[j]; 5 D[o][j]; 6 db[o]; 8 SEQ_LEN; 16+o result[o].
//  CTRL write: bit0 start, bit1 clear hidden, bit2 clear err. STATUS read: {29'b0, err, busy, valid}.
//  Reads combinational: data_out = read ? value : 0; results sign-extended to 32 bits; unmapped addr -> 0.
//  Reset: state IDLE, valid=busy=err=0, SEQ_LEN=0, hidden and results cleared. Parameter/input arrays not reset.
//  FSM IDLE->STEP_MAC->STEP_ACT->(STEP_MAC|SWAP)->(STEP_MAC|DENSE_MAC)->DENSE_WR->(DENSE_MAC|DONE)->IDLE.
//   IDLE: start write -> busy=1, valid=0, t=0, j=0; next state STEP_MAC (or DENSE_MAC if SEQ_LEN=0).
//   STEP_MAC: acc init b[j]; one product/cycle: E cycles x[t][i]*W[i][j], then H cycles h_prev[k]*U[k][j].
//   STEP_ACT (1 cycle): h_next[j] = tanh(sat16(acc)); j==H-1 -> SWAP else j++, STEP_MAC.
//   SWAP (1 cycle): h_prev <= h_next; t==SEQ_LEN-1 -> DENSE_MAC (o=0) else t++, j=0.
//   DENSE_MAC: acc init db[o]; H cycles h_prev[k]*D[o][k]. DENSE_WR: result[o]=sat16(acc); last o -> DONE.
//   DONE (1 cycle): busy=0, valid=1, back to IDLE. valid stays high until next start or rst.
//  Latency start-write to valid=1: L*(H*(E+H+1)+1) + O*(H+1) + 1 cycles, L=SEQ_LEN (SEQ_LEN=0 -> L=0).
//  Arithmetic: 16x16 signed product (32b), arithmetic >>> FRAC_BITS, accumulate in 32b signed;
//   sat16 clamps to [0x8000,0x7FFF]. tanh is the existing single-cycle tanh module.
//  SEQ_LEN write: data_in[SEQ_BITS:0], values above 2**SEQ_BITS clamp to 2**SEQ_BITS.
//  While busy: any write to addr 1-6, 8 ignored and sets sticky err; start ignored and sets err.
//   CTRL bit1/bit2 and reads still serviced; clear hidden while busy is ignored and sets err.
//  Simultaneous start+clear in IDLE: clear applies first, run starts from zero hidden.
//  Index fields wider than the array wrap modulo array size (upper bits ignored).
//  rst mid-run: aborts immediately to reset state next cycle; partial results discarded.
// STRUCTURE
//  rnn_pkg: state_t enum, address-map localparams, CTRL/STATUS bit positions, sat16 function.
//  Sub-module rnn_mac: signed multiply, FRAC shift, 32b accumulate with init/enable, sat16 output.
//  Arrays: x, W, U, b, D, db, h_prev, h_next as plain register arrays (tensor_1d/tensor_2d reuse permitted).
// TESTING (EMB_BITS=1, RNN_BITS=2, OUT_BITS=1, SEQ_BITS=2, FRAC_BITS=8 unless noted)
//  1 Reset: assert rst 2 cycles -> STATUS=0, result[0]=result[1]=0, reads with read=0 return 0.
//  2 Readout: SEQ_LEN=0, db[0]=0x0040, db[1]=0xFFC0, start -> valid after 2*(4+1)+1=11 cycles; result0=0x00000040, result1=0xFFFFFFC0.
//  3 Timing/values: x[t]=[0x0100,0], W[0][*]=0x0100, U=0,b=0, D=0x0100, SEQ_LEN=3 -> valid at 3*29+11=98 cycles; result0=4*tanh(0x0100) per golden model.
//  4 Saturation: db[0]=0x7F00, D[0][*]=0x0100 with positive hidden -> result0=0x00007FFF; negative mirror -> 0xFFFF8000.
//  5 Busy protection: write W and start mid-run -> W unchanged, err=1, run completes normally; CTRL bit2 -> err=0.
//  6 Persistence: run test 3 twice without clear -> second result differs; with CTRL bit1 between -> identical; rst mid-run -> STATUS=0 next cycle.

Source files
------------

// File: rtl/rnn_pkg.sv
// rnn_pkg: shared types and constants for the sequence RNN engine.
//   state_t   - engine FSM states
//   A_*       - word addresses of the memory map
//   CTRL_*    - CTRL write bit positions; ST_* - STATUS read bit positions
//   sat16     - clamp a 32-bit signed accumulator into 16-bit signed range
package rnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP_MAC,
        S_STEP_ACT,
        S_SWAP,
        S_DENSE_MAC,
        S_DENSE_WR,
        S_DONE
    } state_t;

    localparam logic [31:0] A_CTRL = 32'd0;
    localparam logic [31:0] A_X    = 32'd1;
    localparam logic [31:0] A_W    = 32'd2;
    localparam logic [31:0] A_U    = 32'd3;
    localparam logic [31:0] A_B    = 32'd4;
    localparam logic [31:0] A_D    = 32'd5;
    localparam logic [31:0] A_DB   = 32'd6;
    localparam logic [31:0] A_SEQ  = 32'd8;
    localparam logic [31:0] A_RES  = 32'd16;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CLR_H   = 1;
    localparam int CTRL_CLR_ERR = 2;

    localparam int ST_VALID = 0;
    localparam int ST_BUSY  = 1;
    localparam int ST_ERR   = 2;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)       return 16'sh7FFF;
        else if (v < -32'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

endpackage

// File: rtl/rnn_mac.sv
// rnn_mac: Q-format multiply-accumulate.
//   en       - accumulate this cycle
//   init     - start a new sum from init_val instead of the running acc
//   init_val - bias term (16-bit, sign-extended into the accumulator)
//   a, b     - operands; product is shifted down by FRAC_BITS before adding
//   sat      - accumulator clamped to 16-bit signed
module rnn_mac
    import rnn_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic               clk,
    input  logic               en,
    input  logic               init,
    input  logic signed [15:0] init_val,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [15:0] sat
);
    logic signed [31:0] acc, full, prod, base;

    always_comb begin
        full = 32'(a) * 32'(b);
        prod = full >>> FRAC_BITS;
        base = init ? 32'(init_val) : acc;
    end

    // Accumulator needs no reset: every sum starts with init.
    always_ff @(posedge clk) begin
        if (en) acc <= base + prod;
    end

    assign sat = sat16(acc);
endmodule

// File: rtl/rnn_tanh.sv
// rnn_tanh: single-cycle combinational tanh on 16-bit signed fixed point.
//   x - input (FRAC_BITS fractional bits), y - tanh(x), same format.
// Odd-symmetric piecewise-linear fit on |x|:
//   |x| < 0.5        : y = |x|
//   0.5 <= |x| < 1.5 : y = 0.25 + |x|/2
//   |x| >= 1.5       : y = 1.0
module rnn_tanh #(
    parameter int FRAC_BITS = 8
) (
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);
    localparam logic [16:0] HALF    = 17'(1 << (FRAC_BITS - 1));
    localparam logic [16:0] ONEHALF = 17'(3 << (FRAC_BITS - 1));
    localparam logic [16:0] QUART   = 17'(1 << (FRAC_BITS - 2));
    localparam logic [16:0] ONE     = 17'(1 << FRAC_BITS);

    logic [16:0] mag, m;

    always_comb begin
        // 17 bits so |-32768| is representable
        mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
        if (mag < HALF)         m = mag;
        else if (mag < ONEHALF) m = QUART + (mag >> 1);
        else                    m = ONE;
        y = x[15] ? 16'(17'd0 - m) : m[15:0];
    end
endmodule

// File: rtl/rnn_seq_engine.sv
// rnn_seq_engine: memory-mapped Elman RNN engine.
//   clk, rst        - clock, synchronous active-high reset
//   read, write     - bus strobes
//   addr            - word address (0 CTRL/STATUS, 1 x, 2 W, 3 U, 4 b, 5 D, 6 db,
//                     8 SEQ_LEN, 16+o result[o])
//   data_in         - [15:0] value, [31:24] row index, [23:16] column index
//                     (b[j] takes j from the column field, db[o] takes o from the row field)
//   data_out        - read data, 0 when read is low
// A start runs SEQ_LEN timesteps h = tanh(b + xW + hU), then O dense outputs.
module rnn_seq_engine
    import rnn_pkg::*;
#(
    parameter int EMB_BITS  = 1,
    parameter int RNN_BITS  = 5,
    parameter int OUT_BITS  = 0,
    parameter int SEQ_BITS  = 4,
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);
    localparam int E  = 1 << EMB_BITS;
    localparam int H  = 1 << RNN_BITS;
    localparam int O  = 1 << OUT_BITS;
    localparam int S  = 1 << SEQ_BITS;
    localparam int WE = (EMB_BITS > 0) ? EMB_BITS : 1;
    localparam int WH = (RNN_BITS > 0) ? RNN_BITS : 1;
    localparam int WO = (OUT_BITS > 0) ? OUT_BITS : 1;
    localparam int WS = (SEQ_BITS > 0) ? SEQ_BITS : 1;
    localparam logic [SEQ_BITS:0] SEQ_MAX = (SEQ_BITS + 1)'(S);
    localparam logic [SEQ_BITS:0] T1      = (SEQ_BITS + 1)'(1);

    logic signed [15:0] x_mem  [S][E];
    logic signed [15:0] w_mem  [E][H];
    logic signed [15:0] u_mem  [H][H];
    logic signed [15:0] b_mem  [H];
    logic signed [15:0] d_mem  [O][H];
    logic signed [15:0] db_mem [O];
    logic signed [15:0] h_prev [H];
    logic signed [15:0] h_next [H];
    logic signed [15:0] res    [O];

    state_t            state, state_nx;
    logic [SEQ_BITS:0] seq_len, t;
    logic [WH-1:0]     j;
    logic [WO-1:0]     o;
    logic [15:0]       kc;      // product counter inside a MAC phase
    logic              valid, err, busy;

    // Bus decode; index fields wrap to the array size.
    logic               wr_ctrl, start_req, clr_h_req, clr_err_req, wr_cfg;
    logic signed [15:0] val;
    logic [WS-1:0]      r_s;
    logic [WE-1:0]      r_e, c_e;
    logic [WH-1:0]      r_h, c_h;
    logic [WO-1:0]      r_o;

    assign busy        = (state != S_IDLE);
    assign wr_ctrl     = write && (addr == A_CTRL);
    assign start_req   = wr_ctrl && data_in[CTRL_START];
    assign clr_h_req   = wr_ctrl && data_in[CTRL_CLR_H];
    assign clr_err_req = wr_ctrl && data_in[CTRL_CLR_ERR];
    assign wr_cfg      = write && (((addr >= A_X) && (addr <= A_DB)) || (addr == A_SEQ));
    assign val         = data_in[15:0];
    assign r_s         = WS'(data_in[31:24]) & WS'(S - 1);
    assign r_e         = WE'(data_in[31:24]) & WE'(E - 1);
    assign c_e         = WE'(data_in[23:16]) & WE'(E - 1);
    assign r_h         = WH'(data_in[31:24]) & WH'(H - 1);
    assign c_h         = WH'(data_in[23:16]) & WH'(H - 1);
    assign r_o         = WO'(data_in[31:24]) & WO'(O - 1);

    // Parameter/input arrays: writable only while idle, never reset.
    always_ff @(posedge clk) begin
        if (write && !busy) begin
            case (addr)
                A_X:     x_mem[r_s][c_e] <= val;
                A_W:     w_mem[r_e][c_h] <= val;
                A_U:     u_mem[r_h][c_h] <= val;
                A_B:     b_mem[c_h]      <= val;
                A_D:     d_mem[r_o][c_h] <= val;
                A_DB:    db_mem[r_o]     <= val;
                default: ;
            endcase
        end
    end

    // MAC operand selection: step phase runs E input products then H recurrent ones.
    logic               mac_en, mac_init;
    logic signed [15:0] mac_a, mac_b, mac_init_val, mac_sat, act_y;
    logic [WE-1:0]      k_e;
    logic [WH-1:0]      k_h;

    always_comb begin
        k_e          = WE'(kc);
        k_h          = (state == S_STEP_MAC) ? WH'(kc - 16'(E)) : WH'(kc);
        mac_en       = (state == S_STEP_MAC) || (state == S_DENSE_MAC);
        mac_init     = (kc == 16'd0);
        mac_init_val = (state == S_STEP_MAC) ? b_mem[j] : db_mem[o];
        mac_a        = '0;
        mac_b        = '0;
        if (state == S_DENSE_MAC) begin
            mac_a = h_prev[k_h];
            mac_b = d_mem[o][k_h];
        end else if (kc < 16'(E)) begin
            mac_a = x_mem[WS'(t)][k_e];
            mac_b = w_mem[k_e][j];
        end else begin
            mac_a = h_prev[k_h];
            mac_b = u_mem[k_h][j];
        end
    end

    rnn_mac #(.FRAC_BITS(FRAC_BITS)) u_mac (
        .clk(clk), .en(mac_en), .init(mac_init), .init_val(mac_init_val),
        .a(mac_a), .b(mac_b), .sat(mac_sat)
    );

    rnn_tanh #(.FRAC_BITS(FRAC_BITS)) u_tanh (.x(mac_sat), .y(act_y));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start_req) state_nx = (seq_len == '0) ? S_DENSE_MAC : S_STEP_MAC;
            S_STEP_MAC:  if (kc == 16'(E + H - 1)) state_nx = S_STEP_ACT;
            S_STEP_ACT:  state_nx = (j == WH'(H - 1)) ? S_SWAP : S_STEP_MAC;
            S_SWAP:      state_nx = (t == seq_len - T1) ? S_DENSE_MAC : S_STEP_MAC;
            S_DENSE_MAC: if (kc == 16'(H - 1)) state_nx = S_DENSE_WR;
            S_DENSE_WR:  state_nx = (o == WO'(O - 1)) ? S_DONE : S_DENSE_MAC;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            valid   <= 1'b0;
            err     <= 1'b0;
            seq_len <= '0;
            t       <= '0;
            j       <= '0;
            o       <= '0;
            kc      <= '0;
            for (int i = 0; i < H; i++) begin
                h_prev[i] <= '0;
                h_next[i] <= '0;
            end
            for (int i = 0; i < O; i++) res[i] <= '0;
        end else begin
            state <= state_nx;
            // Sticky: any config write, start or hidden-clear while busy flags misuse.
            err <= (err && !clr_err_req) || (busy && (wr_cfg || start_req || clr_h_req));
            if (!busy && write && (addr == A_SEQ))
                seq_len <= (data_in[SEQ_BITS:0] > SEQ_MAX) ? SEQ_MAX : data_in[SEQ_BITS:0];
            // Same-edge clear and start: clear lands before the first recurrent read.
            if (!busy && clr_h_req)
                for (int i = 0; i < H; i++) h_prev[i] <= '0;
            case (state)
                S_IDLE: if (start_req) begin
                    valid <= 1'b0;
                    t     <= '0;
                    j     <= '0;
                    o     <= '0;
                    kc    <= '0;
                end
                S_STEP_MAC, S_DENSE_MAC: kc <= kc + 16'd1;
                S_STEP_ACT: begin
                    h_next[j] <= act_y;
                    kc        <= '0;
                    if (j != WH'(H - 1)) j <= j + WH'(1);
                end
                S_SWAP: begin
                    h_prev <= h_next;
                    j      <= '0;
                    if (t != seq_len - T1) t <= t + T1;
                end
                S_DENSE_WR: begin
                    res[o] <= mac_sat;
                    kc     <= '0;
                    if (o != WO'(O - 1)) o <= o + WO'(1);
                end
                S_DONE:  valid <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if (read) begin
            if (addr == A_CTRL) begin
                data_out[ST_VALID] = valid;
                data_out[ST_BUSY]  = busy;
                data_out[ST_ERR]   = err;
            end else if (addr == A_SEQ) begin
                data_out = 32'(seq_len);
            end else if ((addr >= A_RES) && (addr < A_RES + 32'(O))) begin
                data_out = 32'(res[WO'(addr - A_RES)]);
            end
        end
    end
endmodule

// File: tb/tb_rnn_seq_engine.sv
// Bench for rnn_seq_engine: directed scenarios plus randomized runs, every
// result checked against a plain-arithmetic Elman RNN model kept here.
module tb_rnn_seq_engine;
    localparam int EB = 1, RB = 2, OB = 1, SB = 2, FB = 8;
    localparam int E = 2, H = 4, O = 2, S = 4;
    localparam int LAT_STEP = H * (E + H + 1) + 1;

    logic        clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0;
    logic [31:0] addr = '0, data_in = '0, data_out;

    rnn_seq_engine #(.EMB_BITS(EB), .RNN_BITS(RB), .OUT_BITS(OB), .SEQ_BITS(SB), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;

    // Reference state
    int mx[S][E], mw[E][H], mu[H][H], mb[H], md[O][H], mdb[O], mh[H], mres[O], mseq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sext16(input int v);
        logic [15:0] s;
        s = v[15:0];
        return int'($signed(s));
    endfunction

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Activation: odd piecewise-linear tanh (0.5 and 1.5 knees, ceiling 1.0)
    function automatic int tanh_ref(input int v);
        int a, y;
        a = (v < 0) ? -v : v;
        if (a < 128)      y = a;
        else if (a < 384) y = 64 + a / 2;
        else              y = 256;
        return (v < 0) ? -y : y;
    endfunction

    task automatic model_run();
        int hn[H];
        int acc;
        for (int ts = 0; ts < mseq; ts++) begin
            for (int jj = 0; jj < H; jj++) begin
                acc = mb[jj];
                for (int e = 0; e < E; e++) acc += (mx[ts][e] * mw[e][jj]) >>> FB;
                for (int k = 0; k < H; k++) acc += (mh[k] * mu[k][jj]) >>> FB;
                hn[jj] = tanh_ref(sat(acc));
            end
            mh = hn;
        end
        for (int oo = 0; oo < O; oo++) begin
            acc = mdb[oo];
            for (int k = 0; k < H; k++) acc += (mh[k] * md[oo][k]) >>> FB;
            mres[oo] = sat(acc);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1 write = 1'b0; addr = '0; data_in = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; read = 1'b1;
        #1 d = data_out;
        read = 1'b0; addr = '0;
    endtask

    // Index field with random upper bits that must be ignored (wrap).
    function automatic logic [7:0] fld(input int idx, input int size);
        return 8'(idx + size * $urandom_range(0, 255 / size));
    endfunction

    task automatic put(input int a, input int r, input int c, input int v);
        int rs, cs;
        case (a)
            1: begin mx[r][c] = sext16(v); rs = S; cs = E; end
            2: begin mw[r][c] = sext16(v); rs = E; cs = H; end
            3: begin mu[r][c] = sext16(v); rs = H; cs = H; end
            4: begin mb[c]    = sext16(v); rs = 1; cs = H; end
            5: begin md[r][c] = sext16(v); rs = O; cs = H; end
            default: begin mdb[r] = sext16(v); rs = O; cs = 1; end
        endcase
        wr(32'(a), {fld(r, rs), fld(c, cs), 16'(v)});
    endtask

    task automatic set_seq(input int v);
        mseq = ((v & 7) > S) ? S : (v & 7);
        wr(32'd8, ($urandom & 32'hFFFF_FFF8) | 32'(v & 7));
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        logic [31:0] st;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rd(32'd0, st);
            if (st[0]) begin ok = 1'b1; return; end
            @(posedge clk); #1;
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_results(input string tag);
        logic [31:0] r;
        for (int oo = 0; oo < O; oo++) begin
            rd(32'd16 + 32'(oo), r);
            chk($sformatf("%s_res%0d", tag, oo), r, 32'(mres[oo]));
        end
    endtask

    task automatic do_run(input string tag, input bit clr);
        logic [31:0] st;
        int t0;
        bit ok;
        if (clr) for (int k = 0; k < H; k++) mh[k] = 0;
        model_run();
        wr(32'd0, clr ? 32'd3 : 32'd1);
        t0 = cyc;
        wait_valid(tag, ok);
        if (ok) chk({tag, "_lat"}, 32'(cyc - t0), 32'(mseq * LAT_STEP + O * (H + 1) + 1));
        rd(32'd0, st);
        chk({tag, "_st"}, st & 32'd3, 32'd1);
        check_results(tag);
    endtask

    logic [31:0] st, r1, r2, r3;
    bit ok;
    int t0;

    initial begin
        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        rd(32'd0, st);  chk("rst_status", st, 32'd0);
        rd(32'd16, r1); chk("rst_res0", r1, 32'd0);
        rd(32'd17, r1); chk("rst_res1", r1, 32'd0);
        for (int k = 0; k < H; k++) mh[k] = 0;
        mseq = 0;

        // Known contents for every parameter/input array.
        for (int a = 0; a < S; a++) for (int b = 0; b < E; b++) put(1, a, b, 0);
        for (int a = 0; a < E; a++) for (int b = 0; b < H; b++) put(2, a, b, 0);
        for (int a = 0; a < H; a++) for (int b = 0; b < H; b++) put(3, a, b, 0);
        for (int b = 0; b < H; b++) put(4, 0, b, 0);
        for (int a = 0; a < O; a++) for (int b = 0; b < H; b++) put(5, a, b, 0);
        for (int a = 0; a < O; a++) put(6, a, 0, 0);

        // 2: dense readout only
        set_seq(0);
        put(6, 0, 0, 16'h0040);
        put(6, 1, 0, 16'hFFC0);
        do_run("readout", 1'b0);
        rd(32'd16, r1); chk("readout_c0", r1, 32'h0000_0040);
        rd(32'd17, r1); chk("readout_c1", r1, 32'hFFFF_FFC0);
        addr = 32'd16; read = 1'b0; #1 chk("read_low", data_out, 32'd0); addr = '0;

        // 3: three timesteps, known hidden value
        put(6, 0, 0, 0); put(6, 1, 0, 0);
        for (int ts = 0; ts < S; ts++) put(1, ts, 0, 16'h0100);
        for (int jj = 0; jj < H; jj++) put(2, 0, jj, 16'h0100);
        for (int oo = 0; oo < O; oo++) for (int k = 0; k < H; k++) put(5, oo, k, 16'h0100);
        set_seq(3);
        do_run("timing", 1'b0);
        rd(32'd16, r1); chk("timing_c0", r1, 32'h0000_0300);

        // 4: saturation both ways on current (positive) hidden state
        set_seq(0);
        put(6, 0, 0, 16'h7F00);
        do_run("sat_pos", 1'b0);
        rd(32'd16, r1); chk("sat_pos_c", r1, 32'h0000_7FFF);
        put(6, 0, 0, 16'h8100);
        for (int k = 0; k < H; k++) put(5, 0, k, 16'hFF00);
        do_run("sat_neg", 1'b0);
        rd(32'd16, r1); chk("sat_neg_c", r1, 32'hFFFF_8000);

        // 6: persistence with recurrent weights
        put(6, 0, 0, 0);
        for (int k = 0; k < H; k++) put(5, 0, k, 16'h0100);
        for (int a = 0; a < H; a++) for (int b = 0; b < H; b++) put(3, a, b, 16'h0040);
        set_seq(1);
        wr(32'd0, 32'd2); for (int k = 0; k < H; k++) mh[k] = 0;
        do_run("pers1", 1'b0); rd(32'd16, r1);
        do_run("pers2", 1'b0); rd(32'd16, r2);
        chk("pers_differs", 32'(r1 != r2), 32'd1);
        wr(32'd0, 32'd2); for (int k = 0; k < H; k++) mh[k] = 0;
        do_run("pers3", 1'b0); rd(32'd16, r3);
        chk("pers_same", r3, r1);

        // 5: busy protection
        set_seq(3);
        model_run();
        wr(32'd0, 32'd1);
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        wr(32'd2, 32'h0000_1234);
        wr(32'd0, 32'd1);
        wr(32'd0, 32'd2);
        wr(32'd8, 32'd1);
        rd(32'd0, st); chk("busy_st", st, 32'd6);
        wait_valid("busy", ok);
        if (ok) chk("busy_lat", 32'(cyc - t0), 32'(3 * LAT_STEP + O * (H + 1) + 1));
        check_results("busy");
        rd(32'd8, st); chk("busy_seq", st, 32'd3);
        rd(32'd0, st); chk("busy_err", st, 32'd5);
        wr(32'd0, 32'd4);
        rd(32'd0, st); chk("err_clr", st, 32'd1);

        // rst mid-run
        wr(32'd0, 32'd1);
        repeat (20) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        rd(32'd0, st);  chk("midrst_st", st, 32'd0);
        rd(32'd16, r1); chk("midrst_res", r1, 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < H; k++) mh[k] = 0;
        mseq = 0;

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            bit big;
            big = (it % 3) == 2;
            for (int a = 0; a < S; a++) for (int b = 0; b < E; b++)
                put(1, a, b, big ? int'($urandom) : int'($urandom_range(0, 1023)) - 512);
            for (int a = 0; a < E; a++) for (int b = 0; b < H; b++)
                put(2, a, b, big ? int'($urandom) : int'($urandom_range(0, 1023)) - 512);
            for (int a = 0; a < H; a++) for (int b = 0; b < H; b++)
                put(3, a, b, int'($urandom_range(0, 255)) - 128);
            for (int b = 0; b < H; b++) put(4, 0, b, int'($urandom_range(0, 511)) - 256);
            for (int a = 0; a < O; a++) for (int b = 0; b < H; b++)
                put(5, a, b, big ? int'($urandom) : int'($urandom_range(0, 1023)) - 512);
            for (int a = 0; a < O; a++) put(6, a, 0, big ? int'($urandom) : int'($urandom_range(0, 511)) - 256);
            set_seq(int'($urandom_range(0, 7)));
            do_run($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
